// File: rtl/ram8_burst_master_pkg.sv
// Shared types and constants for the RAM8 burst initiator.
// Widths are fixed by the RAM8 port: 3-bit word address, 16-bit data.
package ram8_burst_master_pkg;

  localparam int AW = 3;
  localparam int DW = 16;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] word_t;

  typedef struct packed {
    logic  op;
    addr_t base;
    addr_t len;
  } cmd_t;

  // Word addresses wrap 7 -> 0 through the natural 3-bit overflow.
  function automatic addr_t addr_inc(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/ram8_burst_master_burst_counter.sv
// Burst address/length tracker: holds the current word address and the beats left.
// Latency: load/step take effect on the next edge; addr and last are direct register views.
// Backpressure: advances only on step, so a stalled beat leaves addr and last untouched.
module ram8_burst_master_burst_counter
  import ram8_burst_master_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  addr_t base,
  input  addr_t len,
  input  logic  step,
  output addr_t addr,
  output logic  last
);

  addr_t cur_addr;
  addr_t remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= base;
      remaining <= len;
    end else if (step && (remaining != '0)) begin
      cur_addr  <= addr_inc(cur_addr);
      remaining <= remaining - addr_t'(1);
    end
  end

  assign addr = cur_addr;
  assign last = (remaining == '0);

endmodule

// File: rtl/ram8_burst_master.sv
// Burst initiator driving an 8x16 RAM port from a command, a write stream and a read stream.
// Latency: first RAM access the cycle after command accept; read data is combinational from RAM.
// Backpressure: wr_valid/rd_ready gate each beat; commands are held off with cmd_ready while busy.
module ram8_burst_master
  import ram8_burst_master_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_write,
  input  logic [DW-1:0] mem_out,
  output logic          busy,
  output logic          done
);

  state_t state;
  logic   busy_q;
  logic   done_q;
  cmd_t   cmd;
  logic   accept;
  logic   beat;
  logic   cnt_last;
  addr_t  cnt_addr;

  assign cmd    = '{op: cmd_op, base: cmd_base, len: cmd_len};
  assign accept = (state == IDLE) && cmd_valid && !reset;
  assign beat   = ((state == WRITE) && wr_valid) || ((state == READ) && rd_ready);

  ram8_burst_master_burst_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .base  (cmd.base),
    .len   (cmd.len),
    .step  (beat),
    .addr  (cnt_addr),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state  <= (cmd.op == OP_READ) ? READ : WRITE;
            busy_q <= 1'b1;
          end
        end
        WRITE, READ: begin
          if (beat && cnt_last) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // mem_addr tracks the counter in every state, so it simply holds in IDLE.
  assign cmd_ready = (state == IDLE) && !reset;
  assign wr_ready  = (state == WRITE);
  assign mem_addr  = cnt_addr;
  assign mem_in    = (state == WRITE) ? wr_data : '0;
  assign mem_write = (state == WRITE) && wr_valid && !reset;
  assign rd_valid  = (state == READ);
  assign rd_data   = rd_valid ? mem_out : '0;
  assign rd_last   = rd_valid && cnt_last;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ram8_burst_master.sv
// Scoreboard bench for ram8_burst_master against a behavioural RAM8 with combinational read.
// Expected RAM writes and read words are queued at stimulus time and checked by monitors.
module tb_ram8_burst_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [2:0]  cmd_base, cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [15:0] rd_data;
  logic [2:0]  mem_addr;
  logic [15:0] mem_in, mem_out;
  logic        mem_write, busy, done;

  ram8_burst_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_write(mem_write), .mem_out(mem_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM8: registered storage, combinational read
  logic [15:0] ram [8];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) ram[i] <= 16'hF000 + 16'(i);
    end else if (mem_write) begin
      ram[mem_addr] <= mem_in;
    end
  end
  assign mem_out = ram[mem_addr];

  typedef struct packed { logic [2:0] a; logic [15:0] d; } wexp_t;
  typedef struct packed { logic [15:0] d; logic l; } rexp_t;
  wexp_t exp_wr_q [$];
  rexp_t exp_rd_q [$];
  logic [15:0] exp_ram [8];
  logic [15:0] wbuf [8];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_accept = 0;
  int a1, d0, ret_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_w(input logic [2:0] a, input logic [15:0] d);
    exp_wr_q.push_back('{a: a, d: d});
    exp_ram[a] = d;
  endtask

  task automatic push_r(input logic [15:0] d, input logic l);
    exp_rd_q.push_back('{d: d, l: l});
  endtask

  // write-side monitor
  always @(negedge clk) begin
    if (mem_write) begin
      if (reset) begin
        chk("mem_write_in_reset", {31'd0, mem_write}, 32'd0);
      end else if (exp_wr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none queued", mem_addr, mem_in);
      end else begin
        wexp_t e;
        e = exp_wr_q.pop_front();
        chk("wr_addr", {29'd0, mem_addr}, {29'd0, e.a});
        chk("wr_data", {16'd0, mem_in}, {16'd0, e.d});
      end
    end
  end

  // read-side monitor
  always @(negedge clk) begin
    if (rd_valid && rd_ready) begin
      if (exp_rd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_read: data 0x%0h, none queued", rd_data);
      end else begin
        rexp_t e;
        e = exp_rd_q.pop_front();
        chk("rd_data", {16'd0, rd_data}, {16'd0, e.d});
        chk("rd_last", {31'd0, rd_last}, {31'd0, e.l});
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check_idle_state();
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_busy",      {31'd0, busy},      32'd0);
    chk("idle_done",      {31'd0, done},      32'd0);
    chk("idle_wr_ready",  {31'd0, wr_ready},  32'd0);
    chk("idle_rd_valid",  {31'd0, rd_valid},  32'd0);
    chk("idle_rd_last",   {31'd0, rd_last},   32'd0);
    chk("idle_mem_write", {31'd0, mem_write}, 32'd0);
    chk("idle_mem_addr",  {29'd0, mem_addr},  32'd0);
    chk("idle_mem_in",    {16'd0, mem_in},    32'd0);
    chk("idle_rd_data",   {16'd0, rd_data},   32'd0);
  endtask

  task automatic ram_check();
    for (int i = 0; i < 8; i++) chk("ram_word", {16'd0, ram[i]}, {16'd0, exp_ram[i]});
  endtask

  task automatic send_cmd(input logic op, input logic [2:0] base, input logic [2:0] len);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_at_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    last_accept = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic feed_write(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      @(negedge clk);
      while (!wr_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("wr_ready", {31'd0, wr_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    wr_data  = '0;
  endtask

  task automatic recv_read(input int n, input bit stall);
    int got, c;
    logic sp, hl;
    logic [15:0] hd;
    logic [2:0] ha;
    got = 0; c = 0; sp = 1'b0; hd = '0; ha = '0; hl = 1'b0;
    while (got < n && c < 80) begin
      rd_ready = stall ? (c % 3 == 0) : 1'b1;
      @(negedge clk);
      if (sp) begin
        chk("stall_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("stall_rd_data",  {16'd0, rd_data},  {16'd0, hd});
        chk("stall_rd_last",  {31'd0, rd_last},  {31'd0, hl});
        chk("stall_mem_addr", {29'd0, mem_addr}, {29'd0, ha});
      end
      sp = rd_valid && !rd_ready;
      hd = rd_data; ha = mem_addr; hl = rd_last;
      if (rd_valid && rd_ready) got++;
      @(posedge clk);
      #1;
      c++;
    end
    rd_ready = 1'b0;
    chk("rd_word_count", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; preload = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_base = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    for (int i = 0; i < 8; i++) exp_ram[i] = 16'hF000 + 16'(i);
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("cmd_ready_in_reset", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_state();
    @(posedge clk);
    #1;

    // write burst base 2 len 3
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    push_w(3'd2, 16'h1111); push_w(3'd3, 16'h2222);
    push_w(3'd4, 16'h3333); push_w(3'd5, 16'h4444);
    d0 = done_cnt;
    send_cmd(1'b0, 3'd2, 3'd3);
    a1 = last_accept;
    feed_write(4);
    ret_cyc = cyc;

    // read back, offered while the write is in DONE
    push_r(16'h1111, 1'b0); push_r(16'h2222, 1'b0);
    push_r(16'h3333, 1'b0); push_r(16'h4444, 1'b1);
    send_cmd(1'b1, 3'd2, 3'd3);
    chk("done_count_write4", done_cnt - d0, 1);
    chk("done_cycle_write4", done_cyc, ret_cyc);
    chk("accept_spacing_len3", last_accept - a1, 6);
    recv_read(4, 1'b0);

    // wrap write base 6 len 3
    wbuf[0] = 16'hA0A0; wbuf[1] = 16'hA1A1; wbuf[2] = 16'hA2A2; wbuf[3] = 16'hA3A3;
    push_w(3'd6, 16'hA0A0); push_w(3'd7, 16'hA1A1);
    push_w(3'd0, 16'hA2A2); push_w(3'd1, 16'hA3A3);
    send_cmd(1'b0, 3'd6, 3'd3);
    feed_write(4);
    ram_check();

    // backpressured full read base 0 len 7
    push_r(16'hA2A2, 1'b0); push_r(16'hA3A3, 1'b0); push_r(16'h1111, 1'b0);
    push_r(16'h2222, 1'b0); push_r(16'h3333, 1'b0); push_r(16'h4444, 1'b0);
    push_r(16'hA0A0, 1'b0); push_r(16'hA1A1, 1'b1);
    send_cmd(1'b1, 3'd0, 3'd7);
    recv_read(8, 1'b1);

    // reset after 2 of 8 write beats
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h5000 + 16'(i);
    push_w(3'd0, 16'h5000); push_w(3'd1, 16'h5001);
    send_cmd(1'b0, 3'd0, 3'd7);
    d0 = done_cnt;
    feed_write(2);
    wr_valid = 1'b1; wr_data = 16'h5002; reset = 1'b1;
    @(negedge clk);
    chk("reset_cycle_mem_write", {31'd0, mem_write}, 32'd0);
    chk("reset_cycle_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0; wr_valid = 1'b0; wr_data = '0;
    @(negedge clk);
    check_idle_state();
    repeat (3) @(negedge clk);
    chk("no_done_after_reset", done_cnt - d0, 0);
    ram_check();
    @(posedge clk);
    #1;

    // single-word write then read at 7, read offered during DONE
    wbuf[0] = 16'hBEEF;
    push_w(3'd7, 16'hBEEF);
    send_cmd(1'b0, 3'd7, 3'd0);
    a1 = last_accept;
    feed_write(1);
    push_r(16'hBEEF, 1'b1);
    send_cmd(1'b1, 3'd7, 3'd0);
    chk("accept_spacing_len0", last_accept - a1, 3);
    recv_read(1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    chk("done_total", done_cnt, 6);
    ram_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
